// File: rtl/his_sched_pkg.sv
// his_sched_pkg: shared types and widths for the histogram scheduler.
//   state_t  : scheduler FSM states
//   DATA_W   : TDC data / peak result width
//   INT_W    : TDC intensity width
//   NUM_W    : TDC hit-count width
//   BATCH_W  : engine batch-size width
//   TH_W     : engine threshold width
package his_sched_pkg;

    localparam int DATA_W  = 15;
    localparam int INT_W   = 4;
    localparam int NUM_W   = 2;
    localparam int BATCH_W = 9;
    localparam int TH_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_RUN,
        S_REPORT,
        S_GAP,
        S_FIN
    } state_t;

endpackage

// File: rtl/his_sched_pick.sv
// his_sched_pick: combinational lowest-set-bit finder over (mask & ~serviced).
// Ports:
//   mask     in  NCH   channel enables for this scan
//   serviced in  NCH   channels already handled in this scan
//   idx      out CH_W  lowest remaining channel (0 when none)
//   none     out 1     no remaining channel
module his_sched_pick
    import his_sched_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  mask,
    input  logic [NCH-1:0]  serviced,
    output logic [CH_W-1:0] idx,
    output logic            none
);

    logic [NCH-1:0] cand;

    // Scan from the top down so the lowest candidate is the last one written.
    always_comb begin
        cand = mask & ~serviced;
        idx  = '0;
        none = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx  = CH_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/his_sched.sv
// his_sched: time-shares one histogram engine among NCH TDC channels.
// On start, the enabled channels are serviced in ascending order: the engine
// is armed with the latched threshold/batch, fed the channel's TDC stream,
// and its peak result is reported per channel on the res_* handshake.
// Optional build macro: HIS_SCHED_TIMEOUT_EN adds a per-channel RUN timeout
// of TO_CYC cycles that reports res_data=0 with res_to=1.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   start, abort               scan control pulses
//   ch_mask, cfg_th, cfg_batch scan configuration, latched at start
//   tdc_valid/data/int/num     per-channel TDC streams (channel k at slice k)
//   tdc_ready                  per-channel ready back to the TDCs
//   his_en, his_th, his_ibatch engine control
//   his_tdc_*                  muxed stream into the engine
//   his_odata/ovalid/oready    engine result handshake
//   res_valid/ch/data/to/ready per-channel result handshake
//   busy, done                 scan status
module his_sched
    import his_sched_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CH_W   = $clog2(NCH),
    parameter int TO_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH-1:0]       ch_mask,
    input  logic [TH_W-1:0]      cfg_th,
    input  logic [BATCH_W-1:0]   cfg_batch,
    input  logic [NCH-1:0]       tdc_valid,
    input  logic [NCH*DATA_W-1:0] tdc_data,
    input  logic [NCH*INT_W-1:0] tdc_int,
    input  logic [NCH*NUM_W-1:0] tdc_num,
    output logic [NCH-1:0]       tdc_ready,
    output logic                 his_en,
    output logic [TH_W-1:0]      his_th,
    output logic [BATCH_W-1:0]   his_ibatch,
    output logic                 his_tdc_valid,
    output logic [DATA_W-1:0]    his_tdc_data,
    output logic [INT_W-1:0]     his_tdc_int,
    output logic [NUM_W-1:0]     his_tdc_num,
    input  logic                 his_tdc_ready,
    input  logic [DATA_W-1:0]    his_odata,
    input  logic                 his_ovalid,
    output logic                 his_oready,
    output logic                 res_valid,
    output logic [CH_W-1:0]      res_ch,
    output logic [DATA_W-1:0]    res_data,
    output logic                 res_to,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 done
);

    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("his_sched: NCH must be in 2..8");
    end
    if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to
        $error("his_sched: TO_CYC must fit a 16-bit counter");
    end

    state_t              cs, ns;
    logic [NCH-1:0]      mask_q;
    logic [NCH-1:0]      serviced_q;
    logic [TH_W-1:0]     th_q;
    logic [BATCH_W-1:0]  batch_q;
    logic [CH_W-1:0]     sel_q;
    logic [DATA_W-1:0]   res_data_q;
    logic [CH_W-1:0]     res_ch_q;
    logic [CH_W-1:0]     pick_idx;
    logic                pick_none;
    logic                run;
    logic                to_hit;

    his_sched_pick #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_pick (
        .mask     (mask_q),
        .serviced (serviced_q),
        .idx      (pick_idx),
        .none     (pick_none)
    );

`ifdef HIS_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TO_CYC);

    logic [15:0] to_cnt;
    logic        res_to_q;

    // Cleared in PICK so it reads 0 on the first RUN cycle; the timeout
    // fires on the cycle it reaches TO_LIM, so it never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else if (cs == S_PICK) begin
            to_cnt <= '0;
        end else if (cs == S_RUN) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign to_hit = (cs == S_RUN) && (to_cnt == TO_LIM);
    assign res_to = res_to_q;
`else
    assign to_hit = 1'b0;
    assign res_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs <= S_IDLE;
        end else begin
            cs <= ns;
        end
    end

    // Abort outranks every transition but is not looked at in IDLE, so a
    // simultaneous start still begins a scan.
    always_comb begin
        ns = cs;
        if (cs != S_IDLE && abort) begin
            ns = S_IDLE;
        end else begin
            unique case (cs)
                S_IDLE:   if (start) ns = S_PICK;
                S_PICK:   ns = pick_none ? S_FIN : S_RUN;
                S_RUN:    if (his_ovalid || to_hit) ns = S_REPORT;
                S_REPORT: if (res_ready) ns = S_GAP;
                S_GAP:    ns = S_PICK;
                S_FIN:    ns = S_IDLE;
                default:  ns = S_IDLE;
            endcase
        end
    end

    // Configuration, scan progress and result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q     <= '0;
            serviced_q <= '0;
            th_q       <= '0;
            batch_q    <= '0;
            sel_q      <= '0;
            res_data_q <= '0;
            res_ch_q   <= '0;
`ifdef HIS_SCHED_TIMEOUT_EN
            res_to_q   <= 1'b0;
`endif
        end else begin
            if (cs == S_IDLE && start) begin
                mask_q     <= ch_mask;
                th_q       <= cfg_th;
                batch_q    <= cfg_batch;
                serviced_q <= '0;
            end
            if (cs == S_PICK && !pick_none && !abort) begin
                sel_q                <= pick_idx;
                serviced_q[pick_idx] <= 1'b1;
            end
            // A real engine result wins over a timeout landing on the same cycle.
            if (cs == S_RUN && !abort && (his_ovalid || to_hit)) begin
                res_ch_q   <= sel_q;
                res_data_q <= his_ovalid ? his_odata : '0;
`ifdef HIS_SCHED_TIMEOUT_EN
                res_to_q   <= !his_ovalid;
`endif
            end
        end
    end

    // Stream mux: combinational, and gated so the engine only ever sees
    // handshakes while a channel is in RUN.
    assign run = (cs == S_RUN);

    always_comb begin
        tdc_ready     = '0;
        his_tdc_valid = 1'b0;
        his_tdc_data  = '0;
        his_tdc_int   = '0;
        his_tdc_num   = '0;
        if (run) begin
            tdc_ready[sel_q] = his_tdc_ready;
            his_tdc_valid    = tdc_valid[sel_q];
            his_tdc_data     = tdc_data[int'(sel_q)*DATA_W +: DATA_W];
            his_tdc_int      = tdc_int[int'(sel_q)*INT_W +: INT_W];
            his_tdc_num      = tdc_num[int'(sel_q)*NUM_W +: NUM_W];
        end
    end

    assign his_en     = run;
    assign his_oready = run;
    assign his_th     = th_q;
    assign his_ibatch = batch_q;
    assign res_valid  = (cs == S_REPORT);
    assign res_ch     = res_ch_q;
    assign res_data   = res_data_q;
    assign busy       = (cs != S_IDLE);
    assign done       = (cs == S_FIN);

endmodule

// File: tb/tb_his_sched.sv
// tb_his_sched: testbench for his_sched with a behavioural histogram engine
// (peak of the first ibatch samples) and per-channel TDC sources.
// Expected results are queued when a scan starts and compared on each
// res_valid&&res_ready handshake.
module tb_his_sched;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic [3:0]        cfg_th = '0;
    logic [8:0]        cfg_batch = '0;
    logic [NCH-1:0]    tdc_valid;
    logic [NCH*15-1:0] tdc_data;
    logic [NCH*4-1:0]  tdc_int;
    logic [NCH*2-1:0]  tdc_num;
    logic [NCH-1:0]    tdc_ready;
    logic              his_en;
    logic [3:0]        his_th;
    logic [8:0]        his_ibatch;
    logic              his_tdc_valid;
    logic [14:0]       his_tdc_data;
    logic [3:0]        his_tdc_int;
    logic [1:0]        his_tdc_num;
    logic              his_tdc_ready = 1'b1;
    logic [14:0]       his_odata = '0;
    logic              his_ovalid = 1'b0;
    logic              his_oready;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [14:0]       res_data;
    logic              res_to;
    logic              res_ready = 1'b1;
    logic              busy;
    logic              done;

    his_sched #(
        .NCH    (NCH),
        .CH_W   (CH_W),
        .TO_CYC (100)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .abort         (abort),
        .ch_mask       (ch_mask),
        .cfg_th        (cfg_th),
        .cfg_batch     (cfg_batch),
        .tdc_valid     (tdc_valid),
        .tdc_data      (tdc_data),
        .tdc_int       (tdc_int),
        .tdc_num       (tdc_num),
        .tdc_ready     (tdc_ready),
        .his_en        (his_en),
        .his_th        (his_th),
        .his_ibatch    (his_ibatch),
        .his_tdc_valid (his_tdc_valid),
        .his_tdc_data  (his_tdc_data),
        .his_tdc_int   (his_tdc_int),
        .his_tdc_num   (his_tdc_num),
        .his_tdc_ready (his_tdc_ready),
        .his_odata     (his_odata),
        .his_ovalid    (his_ovalid),
        .his_oready    (his_oready),
        .res_valid     (res_valid),
        .res_ch        (res_ch),
        .res_data      (res_data),
        .res_to        (res_to),
        .res_ready     (res_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // TDC sources: each channel replays its table, advancing on its own handshake.
    logic [14:0]    src_tab [NCH][4];
    logic [7:0]     src_ptr [NCH] = '{default: 8'd0};
    logic [NCH-1:0] src_en  = '1;
    logic           src_clr = 1'b0;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            tdc_valid[k]       = src_en[k];
            tdc_data[k*15 +: 15] = src_tab[k][src_ptr[k][1:0]];
            tdc_int[k*4 +: 4]  = 4'(k + 3);
            tdc_num[k*2 +: 2]  = 2'd1;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (src_clr) src_ptr[k] <= 8'd0;
            else if (tdc_valid[k] && tdc_ready[k]) src_ptr[k] <= src_ptr[k] + 8'd1;
        end
    end

    // Behavioural engine: peak of the first ibatch accepted samples.
    logic [8:0]  eng_cnt  = '0;
    logic [14:0] eng_peak = '0;

    always @(posedge clk) begin
        if (!his_en) begin
            eng_cnt    <= '0;
            eng_peak   <= '0;
            his_ovalid <= 1'b0;
            his_odata  <= '0;
        end else if (his_ovalid) begin
            if (his_oready) his_ovalid <= 1'b0;
        end else if (his_tdc_valid && his_tdc_ready) begin
            eng_cnt <= eng_cnt + 9'd1;
            if (his_tdc_data > eng_peak) eng_peak <= his_tdc_data;
            if (eng_cnt + 9'd1 == his_ibatch) begin
                his_ovalid <= 1'b1;
                his_odata  <= (his_tdc_data > eng_peak) ? his_tdc_data : eng_peak;
            end
        end
    end

    function automatic logic [14:0] peak(input int k, input int b);
        logic [14:0] m;
        m = '0;
        for (int i = 0; i < b; i++) begin
            if (src_tab[k][i % 4] > m) m = src_tab[k][i % 4];
        end
        return m;
    endfunction

    typedef struct {
        int ch;
        int data;
        bit to;
    } exp_t;

    exp_t           sb[$];
    logic [NCH-1:0] cur_mask = '0;
    int             bad_ready = 0;
    int             bad_valid = 0;
    int             rv_cycles = 0;
    int             done_cnt  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if ((tdc_ready & ~cur_mask) != '0) bad_ready++;
            if (his_tdc_valid && !his_en) bad_valid++;
            if (res_valid) rv_cycles++;
            if (done) done_cnt++;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_res", 32'(res_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res_ch", 32'(res_ch), 32'(e.ch));
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("res_to", 32'(res_to), 32'(e.to));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] m, input logic [3:0] th,
                            input logic [8:0] b, input bit push);
        ch_mask   = m;
        cfg_th    = th;
        cfg_batch = b;
        start     = 1'b1;
        src_clr   = 1'b1;
        cur_mask  = m;
        if (push) begin
            for (int k = 0; k < NCH; k++) begin
                if (m[k]) begin
                    if (!src_en[k]) sb.push_back('{k, 0, 1'b1});
                    else sb.push_back('{k, int'(peak(k, int'(b))), 1'b0});
                end
            end
        end
        step();
        start   = 1'b0;
        src_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            step();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_rv(input string tag);
        int n = 0;
        while (!res_valid && n < 3000) begin
            step();
            n++;
        end
        chk(tag, 32'(res_valid), 32'd1);
    endtask

    initial begin
        int          d0;
        int          rv0;
        int          unstable;
        int          en_seen;
        logic [14:0] hold_d;
        logic [1:0]  hold_c;

        src_tab[0] = '{15'h0100, 15'h1234, 15'h0010, 15'h0020};
        src_tab[1] = '{15'h0222, 15'h0333, 15'h0011, 15'h0012};
        src_tab[2] = '{15'h0FF0, 15'h0005, 15'h0006, 15'h0007};
        src_tab[3] = '{15'h0444, 15'h0111, 15'h0001, 15'h0002};

        // Reset state
        rstn = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_his_en", 32'(his_en), 32'd0);
        chk("rst_oready", 32'(his_oready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_tdc_ready", 32'(tdc_ready), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_th", 32'(his_th), 32'd0);
        chk("rst_batch", 32'(his_ibatch), 32'd0);
        rstn = 1'b1;
        step();

        // Basic two-channel scan
        do_start(4'b0101, 4'd0, 9'd2, 1'b1);
        chk("pick_en", 32'(his_en), 32'd0);
        chk("pick_busy", 32'(busy), 32'd1);
        step();
        chk("run_en", 32'(his_en), 32'd1);
        chk("run_ready", 32'(tdc_ready), 32'b0001);
        chk("run_mux_data", 32'(his_tdc_data), 32'h0100);
        chk("run_ibatch", 32'(his_ibatch), 32'd2);
        wait_done("t1_done");
        step();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // All-zero mask
        rv0 = rv_cycles;
        do_start(4'b0000, 4'd0, 9'd2, 1'b1);
        chk("z_pick_done", 32'(done), 32'd0);
        step();
        chk("z_done", 32'(done), 32'd1);
        step();
        chk("z_idle", 32'(busy), 32'd0);
        chk("z_no_res", 32'(rv_cycles), 32'(rv0));

        // Backpressure in REPORT
        res_ready = 1'b0;
        do_start(4'b0011, 4'd0, 9'd1, 1'b1);
        wait_rv("bp_rv");
        hold_d   = res_data;
        hold_c   = res_ch;
        unstable = 0;
        en_seen  = 0;
        repeat (10) begin
            step();
            if (res_data !== hold_d || res_ch !== hold_c || !res_valid) unstable++;
            if (his_en || tdc_ready != '0) en_seen++;
        end
        chk("bp_stable", 32'(unstable), 32'd0);
        chk("bp_no_run", 32'(en_seen), 32'd0);
        res_ready = 1'b1;
        wait_done("bp_done");
        step();

        // Abort in RUN of ch1 (ch1 source silent so RUN persists)
        src_en = 4'b1101;
        do_start(4'b0010, 4'd0, 9'd3, 1'b0);
        repeat (4) step();
        chk("ab_run", 32'(his_en), 32'd1);
        d0    = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_en", 32'(his_en), 32'd0);
        chk("ab_res_valid", 32'(res_valid), 32'd0);
        repeat (5) step();
        chk("ab_no_done", 32'(done_cnt), 32'(d0));
        src_en = '1;
        do_start(4'b0011, 4'd0, 9'd2, 1'b1);
        step();
        chk("rescan_ch0", 32'(tdc_ready), 32'b0001);
        wait_done("rescan_done");
        step();

        // Start while busy is ignored
        d0 = done_cnt;
        do_start(4'b0011, 4'd5, 9'd2, 1'b1);
        step();
        ch_mask   = 4'b1111;
        cfg_th    = 4'd9;
        cfg_batch = 9'd7;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("busy_th", 32'(his_th), 32'd5);
        chk("busy_batch", 32'(his_ibatch), 32'd2);
        wait_done("busy_done");
        step();
        chk("busy_one_done", 32'(done_cnt), 32'(d0 + 1));

        // Reset mid-scan clears configuration
        do_start(4'b0001, 4'd7, 9'd3, 1'b0);
        step();
        rstn = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_en", 32'(his_en), 32'd0);
        chk("mrst_th", 32'(his_th), 32'd0);
        chk("mrst_batch", 32'(his_ibatch), 32'd0);
        step();
        rstn = 1'b1;
        step();

`ifdef HIS_SCHED_TIMEOUT_EN
        begin
            int cyc;
            src_en = 4'b1110;
            do_start(4'b0011, 4'd0, 9'd2, 1'b1);
            step();
            chk("to_run", 32'(his_en), 32'd1);
            cyc = 0;
            while (!res_valid && cyc < 500) begin
                step();
                cyc++;
            end
            chk("to_latency", 32'(cyc), 32'd101);
            wait_done("to_done");
            step();
            src_en = '1;
        end
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("bad_ready", 32'(bad_ready), 32'd0);
        chk("bad_valid", 32'(bad_valid), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/his_sched.md
# his_sched

Scheduler that time-shares one `histogram` engine among NCH TDC channels. On each `start` it scans the enabled channels in ascending order. For each channel it arms the engine with the latched threshold and batch, and routes that channel's TDC stream into the engine. It then collects the 15-bit peak result and reports it per channel. It sits between the per-pixel TDC outputs and the single histogram instance, under the top-level frame controller.

## Interface
Parameters:
- NCH, 4: number of TDC channels (2..8).
- CH_W, $clog2(NCH): channel index width.
- TO_CYC, 65535: RUN-state cycle limit per channel (used only with timeout compiled in).

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a scan; ignored while busy.
- abort  in  1  one-cycle pulse; terminates the scan.
- ch_mask  in  NCH  channel enables, latched at start.
- cfg_th  in  4  threshold, latched at start.
- cfg_batch  in  9  batch size, latched at start.
- tdc_valid  in  NCH  per-channel TDC valid.
- tdc_data  in  NCH*15  per-channel TDC data; channel k is at [15k+14:15k].
- tdc_int  in  NCH*4  per-channel intensity.
- tdc_num  in  NCH*2  per-channel hit count.
- tdc_ready  out  NCH  per-channel ready.
- his_en  out  1  engine enable.
- his_th  out  4  engine threshold.
- his_ibatch  out  9  engine batch.
- his_tdc_valid / his_tdc_data / his_tdc_int / his_tdc_num  out  1/15/4/2  muxed stream into the engine.
- his_tdc_ready  in  1  engine ready.
- his_odata  in  15  engine result.
- his_ovalid  in  1  engine result valid.
- his_oready  out  1  engine result ready.
- res_valid  out  1  per-channel result valid.
- res_ch  out  CH_W  channel index of the result.
- res_data  out  15  peak value.
- res_to  out  1  result produced by timeout.
- res_ready  in  1  downstream result ready.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at end of scan.

## Operation
- FSM states: IDLE, PICK, RUN, REPORT, GAP, FIN.
- IDLE: when `start` is high, latch ch_mask, cfg_th and cfg_batch, then go to PICK.
- PICK (1 cycle):
  - Select the lowest enabled channel not yet serviced in this scan, and go to RUN.
  - If no such channel remains, go to FIN.
- RUN:
  - his_en=1.
  - his_tdc_* = selected channel's inputs, forwarded combinationally.
  - tdc_ready[sel] = his_tdc_ready; tdc_ready of every other channel = 0.
  - his_oready=1.
  - On his_ovalid&&his_oready: capture his_odata into res_data, set res_ch=sel and res_to=0, go to REPORT.
- REPORT:
  - res_valid=1, his_en=0, his_tdc_valid=0.
  - Hold res_valid until res_valid&&res_ready, then go to GAP.
- GAP (1 cycle): his_en=0. This forces the engine FSM back to its idle state before the next channel. Go to PICK.
- FIN (1 cycle): done=1, then go to IDLE.
- his_th and his_ibatch always drive the latched values.
- busy=1 in every state except IDLE.
- `abort` in any non-IDLE state:
  - Next state is IDLE; his_en and res_valid drop next cycle.
  - No done pulse; a pending result is discarded.
  - `abort` has priority over all other transitions.
- `start` and `abort` high together in IDLE: start wins; abort is ignored.
- A channel masked off, or a mask of all zeros: no RUN for that channel. An all-zero mask gives IDLE→PICK→FIN, so done is asserted 2 cycles after start.

## Timing
- Reset values: CS=IDLE. All outputs are 0, including tdc_ready, his_en, his_oready, res_*, busy and done.
- Reset mid-scan: immediate return to IDLE; latched configuration cleared to 0.
- From start to first his_en=1: 2 cycles (IDLE→PICK→RUN).
- From his_ovalid handshake to res_valid: 1 cycle.
- Between channels: at least 2 cycles with his_en=0 (REPORT plus GAP).
- Mux path: combinational, zero latency. The engine sees TDC handshakes only in RUN.
- Outputs res_* are registered and stable while res_valid&&!res_ready.

## Configuration
- HIS_SCHED_TIMEOUT_EN defined:
  - A CH_W-independent 16-bit counter clears on entering RUN and increments every RUN cycle.
  - When it reaches TO_CYC, go to REPORT with res_data=0 and res_to=1. GAP then resets the engine.
- HIS_SCHED_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; res_to is tied to 0.

## Structure
- Package his_sched_pkg holds:
  - the state enum;
  - DATA_W=15, INT_W=4, NUM_W=2, BATCH_W=9, TH_W=4.
- Sub-module his_sched_pick: combinational lowest-set-bit finder over (mask & ~serviced). Outputs the index and a `none` flag.
- The serviced bit vector and the sel register live in the top.

## Test plan
- mask=4'b0101, batch=2, th=0, with a stream on ch0 peaked at 0x1234 and on ch2 at 0x0FF0 → res (ch0, 0x1234), then (ch2, 0x0FF0), then a done pulse; tdc_ready[1] and tdc_ready[3] stay 0 throughout.
- mask=0, start → done high exactly 2 cycles after start; res_valid never asserted.
- res_ready held low for 10 cycles in REPORT → res_data and res_ch stable, his_en=0, and the next channel is not started.
- abort issued in RUN of ch1 → IDLE next cycle, busy=0, no done pulse; a following start rescans from ch0.
- With HIS_SCHED_TIMEOUT_EN, TO_CYC=100 and ch0 tdc_valid=0 → res (ch0, 0x0000, res_to=1) 101 cycles after entering RUN; ch1 then proceeds normally.
- start pulsed again while busy → ignored; the latched cfg_th and cfg_batch stay unchanged mid-scan.
